// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_XLEN   = 32;

    localparam logic [3:0] DMEM_MASK_NONE = 4'h0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } type_dmem_arb_state_e;

    typedef struct packed {
        logic                   wr;
        logic                   lock;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_XLEN-1:0]   wdata;
        logic [3:0]             mask;
    } type_dmem_req_s;

endpackage

// File: rtl/dmem_arbiter_rr_arbiter.sv
// Combinational round-robin grant with an optional lock that pins the grant to one requester.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   rr_ptr,
    input  logic               lock_en,
    input  logic [PTR_W-1:0]   lock_owner,
    output logic [NUM_REQ-1:0] grant
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        if (lock_en) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (lock_owner == PTR_W'(i)) grant[i] = valid[i];
            end
        end else begin
            // First pass covers rr_ptr..top, second pass wraps to the bottom.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && valid[i] && (PTR_W'(i) >= rr_ptr)) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && valid[i]) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between requesters; one transaction in flight,
// round-robin with an atomic lock, and range fault for addresses beyond the array.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 32,
    parameter int DMEM_BYTES = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ-1:0]        req_wr_i,
    input  logic [NUM_REQ-1:0]        req_lock_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*XLEN-1:0]   req_wdata_i,
    input  logic [NUM_REQ*4-1:0]      req_mask_i,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [XLEN-1:0]           rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      mem_cs_n_o,
    output logic                      mem_wr_n_o,
    output logic [3:0]                mem_mask_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [XLEN-1:0]           mem_wdata_o,
    input  logic [XLEN-1:0]           mem_rdata_i
);

    localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

    type_dmem_arb_state_e state;
    type_dmem_req_s       req_q;
    type_dmem_req_s       req_sel;

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   sel;
    logic [PTR_W-1:0]   next_ptr;
    logic [PTR_W-1:0]   lock_owner;
    logic               lock_valid;
    logic [NUM_REQ-1:0] grant;
    logic [ADDR_W-1:0]  sel_addr;
    logic [XLEN-1:0]    sel_wdata;
    logic               sel_fault;
    logic               fire;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr_arbiter (
        .valid      (req_valid_i),
        .rr_ptr     (rr_ptr),
        .lock_en    (lock_valid),
        .lock_owner (lock_owner),
        .grant      (grant)
    );

    // Ready is masked during reset so nothing is accepted on the reset edge.
    assign req_ready_o = (state == IDLE && rst_n) ? grant : '0;
    assign fire        = |(req_valid_i & req_ready_o);

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) sel = PTR_W'(i);
        end
    end

    assign sel_addr  = req_addr_i[sel*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata_i[sel*XLEN +: XLEN];
    assign sel_fault = (sel_addr >= ADDR_W'(DMEM_BYTES));

    always_comb begin
        req_sel.wr    = req_wr_i[sel];
        req_sel.lock  = req_lock_i[sel];
        req_sel.addr  = DMEM_ADDR_W'(sel_addr);
        req_sel.wdata = DMEM_XLEN'(sel_wdata);
        req_sel.mask  = req_mask_i[sel*4 +: 4];
    end

    assign next_ptr    = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign rsp_valid_o = (state == RESP) ? (NUM_REQ'(1) << owner) : '0;

    // Bus fields come straight from the captured request and read as zero outside ACCESS.
    assign mem_mask_o  = (mem_cs_n_o || !req_q.wr) ? DMEM_MASK_NONE : req_q.mask;
    assign mem_addr_o  = mem_cs_n_o ? '0 : ADDR_W'(req_q.addr);
    assign mem_wdata_o = mem_cs_n_o ? '0 : XLEN'(req_q.wdata);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_q       <= '0;
            owner       <= '0;
            rr_ptr      <= '0;
            lock_valid  <= 1'b0;
            lock_owner  <= '0;
            mem_cs_n_o  <= 1'b1;
            mem_wr_n_o  <= 1'b1;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire) begin
                        req_q <= req_sel;
                        owner <= sel;
                        if (sel_fault) begin
                            state       <= RESP;
                            rsp_err_o   <= 1'b1;
                            rsp_rdata_o <= '0;
                        end else begin
                            state      <= ACCESS;
                            rsp_err_o  <= 1'b0;
                            mem_cs_n_o <= 1'b0;
                            mem_wr_n_o <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    state       <= RESP;
                    rsp_rdata_o <= req_q.wr ? '0 : mem_rdata_i;
                    mem_cs_n_o  <= 1'b1;
                    mem_wr_n_o  <= 1'b1;
                end
                RESP: begin
                    state <= IDLE;
                    // A faulting access always drops the lock.
                    if (req_q.lock && !rsp_err_o) begin
                        lock_valid <= 1'b1;
                        lock_owner <= owner;
                    end else begin
                        lock_valid <= 1'b0;
                        rr_ptr     <= next_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference of the arbitration and memory contents.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid, req_ready, req_wr, req_lock, rsp_valid;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_mask;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        rsp_err, mem_cs_n, mem_wr_n;
    logic [3:0]  mem_mask;

    logic [31:0] dmem [0:255];
    logic [31:0] ref_mem [0:255];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_idx = '0;
    logic [31:0] poke_val = '0;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.NUM_REQ(2), .XLEN(32), .ADDR_W(32), .DMEM_BYTES(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wr_i(req_wr),
        .req_lock_i(req_lock), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_mask_i(req_mask), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .mem_cs_n_o(mem_cs_n), .mem_wr_n_o(mem_wr_n),
        .mem_mask_o(mem_mask), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Asynchronous-read, synchronous-write memory model of the dmem array.
    assign mem_rdata = dmem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (poke_en) dmem[poke_idx] <= poke_val;
        else if (!mem_cs_n && !mem_wr_n) dmem[mem_addr[9:2]] <= merge(dmem[mem_addr[9:2]], mem_wdata, mem_mask);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic v, input logic w, input logic lk,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        req_valid[p] = v;
        req_wr[p] = w;
        req_lock[p] = lk;
        req_addr[p*32 +: 32] = a;
        req_wdata[p*32 +: 32] = d;
        req_mask[p*4 +: 4] = m;
    endtask

    task automatic preload();
        logic [31:0] v;
        for (int i = 0; i < 256; i++) begin
            v = (i == 4) ? 32'hDEADBEEF : (i == 8) ? 32'h12345678 : $urandom;
            ref_mem[i] = v;
            poke_en = 1'b1;
            poke_idx = 8'(i);
            poke_val = v;
            @(posedge clk);
            #1;
        end
        poke_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b11;
        repeat (2) cyc();
        #1;
        compared++; if (req_ready !== 2'b00) begin mismatched++; $display("FAIL reset_ready: got %b want 00", req_ready); end
        compared++; if (mem_cs_n !== 1'b1) begin mismatched++; $display("FAIL reset_cs_n: got %b want 1", mem_cs_n); end
        compared++; if (mem_wr_n !== 1'b1) begin mismatched++; $display("FAIL reset_wr_n: got %b want 1", mem_wr_n); end
        compared++; if (rsp_valid !== 2'b00) begin mismatched++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
        compared++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin mismatched++; $display("FAIL reset_rsp: got %h/%b want 0/0", rsp_rdata, rsp_err); end
        compared++; if (mem_addr !== 32'h0 || mem_mask !== 4'h0 || mem_wdata !== 32'h0) begin mismatched++; $display("FAIL reset_bus: got %h/%h/%h want 0", mem_addr, mem_mask, mem_wdata); end
        req_valid = 2'b00;
        rst_n = 1'b1;
    endtask

    task automatic test_single_load();
        cyc();
        drive(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
        #1;
        compared++; if (req_ready !== 2'b01) begin mismatched++; $display("FAIL load_ready: got %b want 01", req_ready); end
        cyc();
        req_valid = 2'b00;
        #1;
        compared++; if (mem_cs_n !== 1'b0 || mem_wr_n !== 1'b0) begin mismatched++; $display("FAIL load_access: got cs_n=%b wr_n=%b want 0/0", mem_cs_n, mem_wr_n); end
        compared++; if (mem_mask !== 4'h0) begin mismatched++; $display("FAIL load_mask: got %h want 0", mem_mask); end
        compared++; if (mem_addr !== 32'h10) begin mismatched++; $display("FAIL load_addr: got %h want 10", mem_addr); end
        compared++; if (rsp_valid !== 2'b00) begin mismatched++; $display("FAIL load_early_rsp: got %b want 00", rsp_valid); end
        cyc();
        #1;
        compared++; if (rsp_valid !== 2'b01) begin mismatched++; $display("FAIL load_rsp_valid: got %b want 01", rsp_valid); end
        compared++; if (rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin mismatched++; $display("FAIL load_rdata: got %h/%b want deadbeef/0", rsp_rdata, rsp_err); end
        compared++; if (mem_cs_n !== 1'b1) begin mismatched++; $display("FAIL load_cs_release: got %b want 1", mem_cs_n); end
        cyc();
        #1;
        compared++; if (rsp_valid !== 2'b00) begin mismatched++; $display("FAIL load_rsp_one_cycle: got %b want 00", rsp_valid); end
        compared++; if (rsp_rdata !== 32'hDEADBEEF) begin mismatched++; $display("FAIL load_rdata_hold: got %h want deadbeef", rsp_rdata); end
    endtask

    task automatic test_contention();
        logic [1:0] er, ev;
        int own;
        cyc();
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h14, 32'h0, 4'h0);
        cyc();
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) cyc();
            #1;
            own = (c / 3) % 2;
            er = (c % 3 == 0) ? 2'(1 << own) : 2'b00;
            ev = (c % 3 == 2) ? 2'(1 << own) : 2'b00;
            compared++; if (req_ready !== er) begin mismatched++; $display("FAIL contend_ready c=%0d: got %b want %b", c, req_ready, er); end
            compared++; if (rsp_valid !== ev) begin mismatched++; $display("FAIL contend_rsp c=%0d: got %b want %b", c, rsp_valid, ev); end
            if (c % 3 == 2) begin
                compared++; if (rsp_rdata !== ref_mem[4 + own]) begin mismatched++; $display("FAIL contend_rdata c=%0d: got %h want %h", c, rsp_rdata, ref_mem[4 + own]); end
            end
        end
        req_valid = 2'b00;
    endtask

    task automatic test_store_mask();
        logic [31:0] exp_word;
        cyc();
        drive(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'hA5A5A5A5, 4'b0011);
        #1;
        compared++; if (req_ready !== 2'b10) begin mismatched++; $display("FAIL store_ready: got %b want 10", req_ready); end
        cyc();
        req_valid = 2'b00;
        #1;
        compared++; if (mem_cs_n !== 1'b0 || mem_mask !== 4'b0011) begin mismatched++; $display("FAIL store_bus: got cs_n=%b mask=%b want 0/0011", mem_cs_n, mem_mask); end
        compared++; if (mem_wdata !== 32'hA5A5A5A5 || mem_addr !== 32'h20) begin mismatched++; $display("FAIL store_data: got %h@%h want a5a5a5a5@20", mem_wdata, mem_addr); end
        cyc();
        #1;
        compared++; if (rsp_valid !== 2'b10 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin mismatched++; $display("FAIL store_rsp: got %b/%h/%b want 10/0/0", rsp_valid, rsp_rdata, rsp_err); end
        exp_word = 32'h1234A5A5;
        ref_mem[8] = exp_word;
        cyc();
        drive(1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 4'hF);
        #1;
        compared++; if (req_ready !== 2'b10) begin mismatched++; $display("FAIL store_reload_ready: got %b want 10", req_ready); end
        cyc();
        req_valid = 2'b00;
        #1;
        compared++; if (mem_mask !== 4'h0) begin mismatched++; $display("FAIL store_reload_mask: got %h want 0", mem_mask); end
        cyc();
        #1;
        compared++; if (rsp_valid !== 2'b10 || rsp_rdata !== exp_word) begin mismatched++; $display("FAIL store_readback: got %b/%h want 10/%h", rsp_valid, rsp_rdata, exp_word); end
    endtask

    task automatic test_lock();
        logic [1:0] er, ev;
        logic [31:0] ed;
        for (int c = 0; c <= 10; c++) begin
            cyc();
            if (c == 0)      drive(0, 1'b1, 1'b0, 1'b1, 32'h30, 32'h0, 4'h0);
            else if (c == 5) drive(0, 1'b1, 1'b1, 1'b0, 32'h30, 32'hCAFEF00D, 4'hF);
            else             req_valid[0] = 1'b0;
            drive(1, (c <= 8), 1'b0, 1'b0, 32'h34, 32'h0, 4'h0);
            #1;
            er = (c == 0 || c == 5) ? 2'b01 : (c == 8) ? 2'b10 : 2'b00;
            ev = (c == 2 || c == 7) ? 2'b01 : (c == 10) ? 2'b10 : 2'b00;
            ed = (c == 2) ? ref_mem[12] : (c == 7) ? 32'h0 : ref_mem[13];
            compared++; if (req_ready !== er) begin mismatched++; $display("FAIL lock_ready c=%0d: got %b want %b", c, req_ready, er); end
            compared++; if (rsp_valid !== ev) begin mismatched++; $display("FAIL lock_rsp c=%0d: got %b want %b", c, rsp_valid, ev); end
            if (ev != 2'b00) begin
                compared++; if (rsp_rdata !== ed) begin mismatched++; $display("FAIL lock_rdata c=%0d: got %h want %h", c, rsp_rdata, ed); end
            end
            if (c == 5) ref_mem[12] = 32'hCAFEF00D;
        end
        req_valid = 2'b00;
    endtask

    task automatic test_fault();
        cyc();
        drive(0, 1'b1, 1'b0, 1'b1, 32'h400, 32'h0, 4'h0);
        #1;
        compared++; if (req_ready !== 2'b01) begin mismatched++; $display("FAIL fault_ready: got %b want 01", req_ready); end
        cyc();
        req_valid = 2'b00;
        #1;
        compared++; if (mem_cs_n !== 1'b1) begin mismatched++; $display("FAIL fault_no_access: got cs_n=%b want 1", mem_cs_n); end
        compared++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin mismatched++; $display("FAIL fault_rsp: got %b/%b/%h want 01/1/0", rsp_valid, rsp_err, rsp_rdata); end
        cyc();
        drive(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h3FC, 32'h0, 4'h0);
        #1;
        compared++; if (req_ready !== 2'b10) begin mismatched++; $display("FAIL fault_unlock_ready: got %b want 10", req_ready); end
        cyc();
        req_valid = 2'b00;
        #1;
        compared++; if (mem_cs_n !== 1'b0 || mem_addr !== 32'h3FC) begin mismatched++; $display("FAIL top_word_access: got cs_n=%b addr=%h want 0/3fc", mem_cs_n, mem_addr); end
        cyc();
        #1;
        compared++; if (rsp_valid !== 2'b10 || rsp_err !== 1'b0 || rsp_rdata !== ref_mem[255]) begin mismatched++; $display("FAIL top_word_rsp: got %b/%b/%h want 10/0/%h", rsp_valid, rsp_err, rsp_rdata, ref_mem[255]); end
    endtask

    task automatic test_reset_midop();
        cyc();
        drive(1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 4'h0);
        #1;
        compared++; if (req_ready !== 2'b10) begin mismatched++; $display("FAIL midop_ready: got %b want 10", req_ready); end
        cyc();
        req_valid = 2'b00;
        #1;
        compared++; if (mem_cs_n !== 1'b0) begin mismatched++; $display("FAIL midop_access: got cs_n=%b want 0", mem_cs_n); end
        rst_n = 1'b0;
        cyc();
        #1;
        compared++; if (rsp_valid !== 2'b00 || mem_cs_n !== 1'b1) begin mismatched++; $display("FAIL midop_dropped: got rsp=%b cs_n=%b want 00/1", rsp_valid, mem_cs_n); end
        rst_n = 1'b1;
        drive(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
        #1;
        compared++; if (req_ready !== 2'b01) begin mismatched++; $display("FAIL midop_idle: got ready=%b want 01", req_ready); end
        req_valid = 2'b00;
    endtask

    task automatic test_random();
        logic        pend [2];
        logic        p_wr [2];
        logic        p_lk [2];
        logic [31:0] p_ad [2];
        logic [31:0] p_wd [2];
        logic [3:0]  p_mk [2];
        int rr_m = 0, lock_m = -1, next_idle = 0;
        int acc_c = -1, rsp_c = -1, rsp_own = 0, w, r;
        logic [31:0] exp_data, exp_addr;
        logic [3:0]  exp_mask;
        logic        exp_err, fault;
        logic [1:0]  er, ev;
        pend[0] = 1'b0; pend[1] = 1'b0;
        exp_data = '0; exp_addr = '0; exp_mask = '0; exp_err = 1'b0;
        for (int c = 0; c < 400; c++) begin
            cyc();
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(1, 0) == 1) begin
                    pend[p] = 1'b1;
                    p_wr[p] = 1'($urandom_range(1, 0));
                    p_lk[p] = ($urandom_range(3, 0) == 0);
                    r = $urandom_range(15, 0);
                    p_ad[p] = (r == 0) ? 32'h400 + 32'($urandom_range(63, 0) * 4) :
                              (r == 1) ? 32'h3FC : 32'($urandom_range(255, 0) * 4);
                    p_wd[p] = $urandom;
                    p_mk[p] = 4'($urandom_range(15, 0));
                end
                drive(p, pend[p], p_wr[p], p_lk[p], p_ad[p], p_wd[p], p_mk[p]);
            end
            #1;
            w = -1;
            if (c >= next_idle) begin
                if (lock_m >= 0) begin
                    if (pend[lock_m]) w = lock_m;
                end else begin
                    for (int k = 0; k < 2; k++) if (w < 0 && pend[(rr_m + k) % 2]) w = (rr_m + k) % 2;
                end
            end
            er = (w >= 0) ? 2'(1 << w) : 2'b00;
            ev = (c == rsp_c) ? 2'(1 << rsp_own) : 2'b00;
            compared++; if (req_ready !== er) begin mismatched++; $display("FAIL rand_ready c=%0d: got %b want %b", c, req_ready, er); end
            compared++; if (rsp_valid !== ev) begin mismatched++; $display("FAIL rand_rsp c=%0d: got %b want %b", c, rsp_valid, ev); end
            compared++; if (mem_cs_n !== (c != acc_c)) begin mismatched++; $display("FAIL rand_cs_n c=%0d: got %b want %b", c, mem_cs_n, (c != acc_c)); end
            if (c == rsp_c) begin
                compared++; if (rsp_rdata !== exp_data || rsp_err !== exp_err) begin mismatched++; $display("FAIL rand_rdata c=%0d: got %h/%b want %h/%b", c, rsp_rdata, rsp_err, exp_data, exp_err); end
            end
            if (c == acc_c) begin
                compared++; if (mem_addr !== exp_addr || mem_mask !== exp_mask) begin mismatched++; $display("FAIL rand_bus c=%0d: got %h/%h want %h/%h", c, mem_addr, mem_mask, exp_addr, exp_mask); end
            end
            if (w >= 0) begin
                fault = (p_ad[w] >= 32'd1024);
                acc_c = fault ? -1 : c + 1;
                rsp_c = fault ? c + 1 : c + 2;
                next_idle = rsp_c + 1;
                rsp_own = w;
                exp_err = fault;
                exp_addr = p_ad[w];
                exp_mask = p_wr[w] ? p_mk[w] : 4'h0;
                exp_data = (fault || p_wr[w]) ? 32'h0 : ref_mem[p_ad[w][9:2]];
                if (!fault && p_wr[w]) ref_mem[p_ad[w][9:2]] = merge(ref_mem[p_ad[w][9:2]], p_wd[w], p_mk[w]);
                if (p_lk[w] && !fault) lock_m = w;
                else begin
                    lock_m = -1;
                    rr_m = (w + 1) % 2;
                end
                pend[w] = 1'b0;
            end
        end
        req_valid = 2'b00;
    endtask

    initial begin
        req_valid = '0; req_wr = '0; req_lock = '0;
        req_addr = '0; req_wdata = '0; req_mask = '0;
        rst_n = 1'b0;
        preload();
        test_reset();
        test_single_load();
        test_contention();
        test_store_mask();
        test_lock();
        test_fault();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
